// File: rtl/key_event_decoder.sv
// Classifies debounced active-low key activity into SHORT/DOUBLE/LONG events on a valid/ready port.
// Optional build macro KEY_REPEAT_EN adds periodic REPEAT events while a long press is held.
module key_event_decoder #(
   parameter int LONG_CNT   = 50,
   parameter int DCLICK_GAP = 20,
   parameter int REPEAT_CNT = 25,
   parameter int CNT_W      = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_in,
   output logic       evt_valid,
   output logic [1:0] evt_code,
   input  logic       evt_ready,
   output logic       evt_ovf
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS1,
      GAP,
      PRESS2,
      HELD
   } state_t;

   localparam logic [1:0] CODE_SHORT  = 2'd0;
   localparam logic [1:0] CODE_DOUBLE = 2'd1;
   localparam logic [1:0] CODE_LONG   = 2'd2;

   // The counter saturates at the largest terminal count it ever has to reach.
   localparam int CNT_MAX_A = (LONG_CNT > DCLICK_GAP) ? LONG_CNT : DCLICK_GAP;
   localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_CNT) ? CNT_MAX_A : REPEAT_CNT;

   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(DCLICK_GAP - 1);
`ifdef KEY_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CNT - 1);
`endif

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic             raise;
   logic [1:0]       raise_code;

   assign cnt_inc = (cnt >= CNT_SAT) ? cnt : cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Terminal compares use cnt == N-1, which equals cnt+1 == N without widening.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      raise      = 1'b0;
      raise_code = CODE_SHORT;
      case (state)
         IDLE: begin
            if (!key_in) begin
               state_nxt = PRESS1;
               cnt_nxt   = CNT_W'(1);
            end
         end
         PRESS1: begin
            if (key_in) begin
               state_nxt = GAP;
               cnt_nxt   = CNT_W'(1);
            end else if (cnt == LONG_M1) begin
               raise      = 1'b1;
               raise_code = CODE_LONG;
               state_nxt  = HELD;
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         GAP: begin
            if (!key_in) begin
               state_nxt = PRESS2;
               cnt_nxt   = '0;
            end else if (cnt == GAP_M1) begin
               raise      = 1'b1;
               raise_code = CODE_SHORT;
               state_nxt  = IDLE;
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         PRESS2: begin
            if (key_in) begin
               raise      = 1'b1;
               raise_code = CODE_DOUBLE;
               state_nxt  = IDLE;
               cnt_nxt    = '0;
            end
         end
         HELD: begin
            if (key_in) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
`ifdef KEY_REPEAT_EN
               if (cnt == REP_M1) begin
                  raise      = 1'b1;
                  raise_code = 2'd3;
                  cnt_nxt    = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
`else
               cnt_nxt = cnt;
`endif
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // A new event wins over an accept on the same edge; an unaccepted pending event is never overwritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_code  <= 2'd0;
         evt_ovf   <= 1'b0;
      end else if (raise) begin
         if (!evt_valid || evt_ready) begin
            evt_valid <= 1'b1;
            evt_code  <= raise_code;
         end else begin
            evt_ovf <= 1'b1;
         end
      end else if (evt_valid && evt_ready) begin
         evt_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed gestures plus randomized key runs against a gesture-level model.
module tb_key_event_decoder;

   localparam int LONG_CNT   = 8;
   localparam int DCLICK_GAP = 4;
   localparam int REPEAT_CNT = 5;
   localparam int CNT_W      = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       key_in = 1'b1;
   logic       evt_ready = 1'b1;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic       evt_ovf;

   int errors = 0;
   int checks = 0;

   // Gesture model: presses started in this gesture, run lengths, and whether a long press is active.
   int         presses;
   int         low_run;
   int         high_run;
   bit         held;
   logic       exp_valid;
   logic [1:0] exp_code;
   logic       exp_ovf;

   always #5 clk = ~clk;

   key_event_decoder #(
      .LONG_CNT  (LONG_CNT),
      .DCLICK_GAP(DCLICK_GAP),
      .REPEAT_CNT(REPEAT_CNT),
      .CNT_W     (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_in   (key_in),
      .evt_valid(evt_valid),
      .evt_code (evt_code),
      .evt_ready(evt_ready),
      .evt_ovf  (evt_ovf)
   );

   task automatic checkBit(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic checkCode(input string tag, input logic [1:0] obs, input logic [1:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkBit({tag, ".valid"}, evt_valid, exp_valid);
      checkCode({tag, ".code"}, evt_code, exp_code);
      checkBit({tag, ".ovf"}, evt_ovf, exp_ovf);
   endtask

   task automatic clearGesture();
      presses  = 0;
      low_run  = 0;
      high_run = 0;
      held     = 0;
   endtask

   task automatic modelReset();
      clearGesture();
      exp_valid = 1'b0;
      exp_code  = 2'd0;
      exp_ovf   = 1'b0;
   endtask

   task automatic modelStep(input logic k, input logic rdy);
      bit         raise;
      logic [1:0] code;
      raise = 0;
      code  = 2'd0;
      if (!k) begin
         if (held) begin
            low_run++;
`ifdef KEY_REPEAT_EN
            if ((low_run - LONG_CNT) % REPEAT_CNT == 0) begin
               raise = 1;
               code  = 2'd3;
            end
`endif
         end else if (presses == 0) begin
            presses  = 1;
            low_run  = 1;
            high_run = 0;
         end else if (presses == 1 && high_run == 0) begin
            low_run++;
            if (low_run == LONG_CNT) begin
               raise = 1;
               code  = 2'd2;
               held  = 1;
            end
         end else if (presses == 1) begin
            presses = 2;
         end
      end else begin
         if (held) begin
            clearGesture();
         end else if (presses == 2) begin
            raise = 1;
            code  = 2'd1;
            clearGesture();
         end else if (presses == 1) begin
            high_run++;
            if (high_run == DCLICK_GAP) begin
               raise = 1;
               code  = 2'd0;
               clearGesture();
            end
         end
      end
      if (raise) begin
         if (!exp_valid || rdy) begin
            exp_valid = 1'b1;
            exp_code  = code;
         end else begin
            exp_ovf = 1'b1;
         end
      end else if (exp_valid && rdy) begin
         exp_valid = 1'b0;
      end
   endtask

   // Called at a falling edge; drives one sample, advances the model at the rising edge, checks at the next fall.
   task automatic applyStimulus(input logic k, input logic rdy, input string tag);
      key_in    = k;
      evt_ready = rdy;
      @(posedge clk);
      modelStep(k, rdy);
      @(negedge clk);
      checkOutput(tag);
   endtask

   task automatic runKey(input logic k, input int n, input int rdy_mode, input string tag);
      for (int i = 0; i < n; i++) begin
         logic rdy;
         rdy = (rdy_mode == 2) ? logic'($urandom_range(0, 3) != 0) : logic'(rdy_mode[0]);
         applyStimulus(k, rdy, tag);
      end
   endtask

   task automatic doReset(input int n);
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("reset");
      repeat (n) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      modelReset();
      @(negedge clk);
      doReset(2);

      $display("[TB] short click");
      runKey(1'b0, 3, 1, "short.low");
      runKey(1'b1, 3, 1, "short.high");
      checkBit("short.not_yet", evt_valid, 1'b0);
      runKey(1'b1, 1, 1, "short.high4");
      checkBit("short.valid", evt_valid, 1'b1);
      checkCode("short.code", evt_code, 2'd0);
      runKey(1'b1, 3, 1, "short.idle");
      checkBit("short.accepted", evt_valid, 1'b0);

      $display("[TB] double click");
      runKey(1'b0, 3, 1, "dbl.low1");
      runKey(1'b1, 2, 1, "dbl.high1");
      runKey(1'b0, 3, 1, "dbl.low2");
      runKey(1'b1, 1, 1, "dbl.rel");
      checkBit("dbl.valid", evt_valid, 1'b1);
      checkCode("dbl.code", evt_code, 2'd1);
      runKey(1'b1, 6, 1, "dbl.idle");
      checkBit("dbl.no_short", evt_valid, 1'b0);

      $display("[TB] long press");
      runKey(1'b0, 8, 1, "long.low");
      checkBit("long.valid", evt_valid, 1'b1);
      checkCode("long.code", evt_code, 2'd2);
      runKey(1'b0, 12, 1, "long.hold");
      runKey(1'b1, 6, 1, "long.rel");
      checkBit("long.no_release_evt", evt_valid, 1'b0);

      $display("[TB] overflow");
      runKey(1'b0, 3, 0, "ovf.low1");
      runKey(1'b1, 4, 0, "ovf.high1");
      runKey(1'b0, 3, 0, "ovf.low2");
      runKey(1'b1, 4, 0, "ovf.high2");
      checkBit("ovf.valid", evt_valid, 1'b1);
      checkCode("ovf.code", evt_code, 2'd0);
      checkBit("ovf.flag", evt_ovf, 1'b1);
      runKey(1'b1, 1, 1, "ovf.accept");
      checkBit("ovf.cleared", evt_valid, 1'b0);
      checkBit("ovf.sticky", evt_ovf, 1'b1);

      $display("[TB] reset during press");
      doReset(1);
      runKey(1'b0, 6, 1, "rst.low");
      key_in = 1'b0;
      doReset(2);
      runKey(1'b0, 7, 1, "rst.relow");
      checkBit("rst.no_long", evt_valid, 1'b0);
      runKey(1'b0, 1, 1, "rst.low8");
      checkBit("rst.long_valid", evt_valid, 1'b1);
      checkCode("rst.long_code", evt_code, 2'd2);
      runKey(1'b1, 2, 1, "rst.rel");

      $display("[TB] accept with simultaneous raise");
      doReset(1);
      runKey(1'b0, 3, 0, "acc.low1");
      runKey(1'b1, 4, 0, "acc.high1");
      runKey(1'b0, 7, 0, "acc.low2");
      runKey(1'b0, 1, 1, "acc.low8");
      checkBit("acc.valid", evt_valid, 1'b1);
      checkCode("acc.code", evt_code, 2'd2);
      checkBit("acc.ovf", evt_ovf, 1'b0);
      runKey(1'b1, 2, 1, "acc.rel");

      $display("[TB] boundaries");
      runKey(1'b0, LONG_CNT - 1, 1, "bnd.low");
      runKey(1'b1, DCLICK_GAP, 1, "bnd.high");
      runKey(1'b0, 2, 1, "bnd.low2");
      runKey(1'b1, DCLICK_GAP - 1, 1, "bnd.gap");
      runKey(1'b0, 2, 1, "bnd.press2");
      runKey(1'b1, 6, 1, "bnd.rel");

      $display("[TB] random");
      for (int g = 0; g < 150; g++) begin
         if ($urandom_range(0, 24) == 0) begin
            key_in = logic'($urandom_range(0, 1));
            doReset($urandom_range(1, 2));
         end
         runKey(1'b0, $urandom_range(1, 20), 2, "rnd.low");
         runKey(1'b1, $urandom_range(1, 8), 2, "rnd.high");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the debounced, active-low key level produced by the key debounce stage. The level is already synchronised, idles high, and low means pressed.
- Classifies press activity into discrete events: short click, double click, long press, and optionally auto-repeat.
- Presents one event at a time on a valid/ready interface to the downstream LED/control logic.

Parameters:
LONG_CNT, 50, number of consecutive low samples that qualifies a long press (min 2)
DCLICK_GAP, 20, number of consecutive high samples after a first click that closes the double-click window (min 2)
REPEAT_CNT, 25, cycles between REPEAT events while held after LONG (used only with the optional feature)
CNT_W, 16, width of the internal cycle counter; must hold max(LONG_CNT, DCLICK_GAP, REPEAT_CNT)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
key_in  input  1  debounced key level, 0 = pressed, idle 1
evt_valid  output  1  event pending
evt_code  output  2  event type: 0 SHORT, 1 DOUBLE, 2 LONG, 3 REPEAT
evt_ready  input  1  consumer accepts the pending event
evt_ovf  output  1  sticky flag: an event was dropped

Behaviour:
- Single clock `clk`; reset `rst_n` is asynchronous, active-low. The reset values below apply immediately on assertion, regardless of clock.
- Reset values: state IDLE, cnt 0, evt_valid 0, evt_code 0, evt_ovf 0.
- key_in is sampled on every rising clk edge; "low run" and "high run" mean counts of consecutive samples.
- FSM states: IDLE, PRESS1, GAP, PRESS2, HELD.
- IDLE:
  - key_in=0 → PRESS1, cnt=1.
  - Otherwise stay in IDLE.
- PRESS1:
  - key_in=1 → GAP, cnt=1.
  - key_in=0 with cnt+1==LONG_CNT → raise LONG, go to HELD, cnt=0.
  - Otherwise cnt+1.
- GAP:
  - key_in=0 → PRESS2.
  - key_in=1 with cnt+1==DCLICK_GAP → raise SHORT, go to IDLE.
  - Otherwise cnt+1.
- PRESS2:
  - key_in=1 → raise DOUBLE, go to IDLE.
  - Press duration is ignored; cnt is not used.
- HELD:
  - key_in=1 → IDLE, no event.
- Latency: the event is raised at the same edge that samples the qualifying condition; evt_valid/evt_code are registered outputs and are visible after that edge.
- Handshake:
  - evt_valid and evt_code stay stable until an edge where evt_valid&&evt_ready. At that edge evt_valid clears, unless a new event is raised at the same edge.
  - If a new event is raised at the same edge as an accept, the new event loads and evt_valid stays 1.
  - If an event is raised while evt_valid=1 and evt_ready=0, the new event is dropped, the old event is kept, and evt_ovf is set to 1.
  - evt_ovf is cleared only by reset.
  - The FSM never stalls on the handshake.
- Counters saturate and never wrap; with legal parameters their terminal compares always occur before saturation.
- Reset mid-operation: all of the above state is lost and no event is emitted. If key_in is still low after reset release, it is treated as a fresh press starting with the first sampled low.

Optional Feature:
Macro: KEY_REPEAT_EN.
- Defined:
  - In HELD with key_in=0, cnt counts each cycle.
  - When cnt+1==REPEAT_CNT, raise REPEAT (code 3) and set cnt=0.
  - REPEAT events are repeated every REPEAT_CNT cycles until release, and follow the same drop/overflow rules as other events.
- Not defined:
  - HELD only waits for release.
  - evt_code never equals 3.
  - The REPEAT counter logic is absent from the design.

Test Plan (LONG_CNT=8, DCLICK_GAP=4, REPEAT_CNT=5, evt_ready=1 unless stated):
- Hold key_in low 3 cycles, then high → exactly one SHORT (code 0), with evt_valid rising after the 4th high sample; no other event.
- Low 3, high 2, low 3, high → one DOUBLE (code 1) after the first high sample of the second release; no SHORT emitted.
- Low 20 cycles, then high → LONG (code 2) after the 8th low sample; no event on release. With KEY_REPEAT_EN: REPEAT (code 3) after low samples 13 and 18, then none after release.
- evt_ready=0, produce SHORT then a second SHORT → evt_code stays 0, evt_valid=1, evt_ovf=1. Raise evt_ready for 1 cycle → evt_valid=0, evt_ovf stays 1.
- Assert rst_n=0 for 2 cycles during PRESS1 at low sample 6, with key_in held low throughout → no LONG emitted. After release, LONG is emitted after 8 further low samples.
- Accept (evt_ready=1) on the same edge a new LONG is raised → evt_valid stays 1, evt_code=2, evt_ovf=0.
